// File: rtl/gmp_pkg.sv
// Shared types for the GMP data/stuff generator: FSM states and accumulator sizing.
package gmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gmp_state_e;

    // Extra bit on top of MPT_W so acc+cm never overflows before the compare.
    localparam int ACC_GUARD = 1;

endpackage

// File: rtl/gmp_ds_gen_if.sv
// Parameter/request side and decision side of the GMP data/stuff generator.
interface gmp_ds_gen_if #(
    parameter int MPT_W = 8,
    parameter int LANES = 4
);
    logic [MPT_W-1:0] pm;
    logic [MPT_W-1:0] cm;
    logic             sof;
    logic             valid_in;
    logic             sof_out;
    logic             valid_out;
    logic             eof_out;
    logic [LANES-1:0] ds;
    logic [LANES-1:0] ds_mask;
    logic             err_sof_early;
    logic             err_sof_late;
    logic             err_param;

    modport master (
        output pm, cm, sof, valid_in,
        input  sof_out, valid_out, eof_out, ds, ds_mask,
               err_sof_early, err_sof_late, err_param
    );

    modport slave (
        input  pm, cm, sof, valid_in,
        output sof_out, valid_out, eof_out, ds, ds_mask,
               err_sof_early, err_sof_late, err_param
    );
endinterface

// File: rtl/gmp_lane_step.sv
// One GMP slot decision: add cm, wrap by a single conditional subtract of pm.
module gmp_lane_step
    import gmp_pkg::*;
#(
    parameter int MPT_W = 8
) (
    input  logic [MPT_W-1:0] acc,
    input  logic [MPT_W-1:0] cm,
    input  logic [MPT_W-1:0] pm,
    input  logic             en,
    output logic [MPT_W-1:0] acc_nxt,
    output logic             ds
);
    localparam int ACC_W = MPT_W + ACC_GUARD;

    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] pm_x;
    logic             wrap;

    assign sum  = ACC_W'(acc) + ACC_W'(cm);
    assign pm_x = ACC_W'(pm);
    assign wrap = (sum >= pm_x);

    // acc < pm and cm <= pm keep both branches below 2^MPT_W, so truncation is lossless.
    assign acc_nxt = !en ? acc : (wrap ? MPT_W'(sum - pm_x) : MPT_W'(sum));
    assign ds      = en & wrap;
endmodule

// File: rtl/gmp_ds_gen.sv
// GMP data/stuff generator: LANES slot decisions per beat over a frame of pm slots.
//   state | meaning
//   IDLE  | waiting for sof with a legal (pm, cm) pair
//   RUN   | frame accepted, emitting one beat per valid_in until rem is spent
module gmp_ds_gen
    import gmp_pkg::*;
#(
    parameter int MPT_W = 8,
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    gmp_ds_gen_if.slave  bus
);
    localparam logic [MPT_W-1:0] LANES_W = MPT_W'(LANES);

    gmp_state_e       state;
    logic [MPT_W-1:0] pm_q;
    logic [MPT_W-1:0] cm_q;
    logic [MPT_W-1:0] acc_q;
    logic [MPT_W-1:0] rem_q;

    logic             sof_out_q;
    logic             valid_out_q;
    logic             eof_out_q;
    logic [LANES-1:0] ds_q;
    logic [LANES-1:0] ds_mask_q;
    logic             err_early_q;
    logic             err_late_q;
    logic             err_param_q;

    logic [MPT_W-1:0] acc_chain [LANES+1];
    logic [LANES-1:0] ds_c;
    logic [LANES-1:0] en_c;
    logic             param_ok;

    assign param_ok     = (bus.pm != '0) && (bus.cm <= bus.pm);
    assign acc_chain[0] = acc_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign en_c[k] = (MPT_W'(k) < rem_q);

        gmp_lane_step #(.MPT_W(MPT_W)) u_step (
            .acc     (acc_chain[k]),
            .cm      (cm_q),
            .pm      (pm_q),
            .en      (en_c[k]),
            .acc_nxt (acc_chain[k+1]),
            .ds      (ds_c[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pm_q        <= '0;
            cm_q        <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            sof_out_q   <= 1'b0;
            valid_out_q <= 1'b0;
            eof_out_q   <= 1'b0;
            ds_q        <= '0;
            ds_mask_q   <= '0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            err_param_q <= 1'b0;
        end else begin
            sof_out_q   <= 1'b0;
            valid_out_q <= 1'b0;
            eof_out_q   <= 1'b0;
            ds_q        <= '0;
            ds_mask_q   <= '0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            err_param_q <= 1'b0;

            // sof takes priority over valid_in: a beat in the sof cycle is the header.
            if (bus.sof) begin
                if (state == RUN) begin
                    err_early_q <= 1'b1;
                end
                if (param_ok) begin
                    pm_q      <= bus.pm;
                    cm_q      <= bus.cm;
                    acc_q     <= '0;
                    rem_q     <= bus.pm;
                    state     <= RUN;
                    sof_out_q <= 1'b1;
                end else begin
                    err_param_q <= 1'b1;
                    state       <= IDLE;
                end
            end else if (bus.valid_in) begin
                if (state == IDLE) begin
                    err_late_q <= 1'b1;
                end else begin
                    valid_out_q <= 1'b1;
                    ds_q        <= ds_c;
                    ds_mask_q   <= en_c;
                    acc_q       <= acc_chain[LANES];
                    rem_q       <= rem_q - LANES_W;
                    if (rem_q <= LANES_W) begin
                        eof_out_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
            end
        end
    end

    assign bus.sof_out       = sof_out_q;
    assign bus.valid_out     = valid_out_q;
    assign bus.eof_out       = eof_out_q;
    assign bus.ds            = ds_q;
    assign bus.ds_mask       = ds_mask_q;
    assign bus.err_sof_early = err_early_q;
    assign bus.err_sof_late  = err_late_q;
    assign bus.err_param     = err_param_q;
endmodule

// File: tb/tb_gmp_ds_gen.sv
// Directed bench for gmp_ds_gen (MPT_W=8, LANES=4) with hand-computed beat outputs.
module tb_gmp_ds_gen;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    gmp_ds_gen_if #(.MPT_W(8), .LANES(4)) bus ();

    gmp_ds_gen #(.MPT_W(8), .LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Packed view: {sof_out, valid_out, eof_out, ds[3:0], ds_mask[3:0], err_early, err_late, err_param}
    function automatic logic [31:0] pk(input logic so, input logic vo, input logic eo,
                                       input logic [3:0] d, input logic [3:0] m,
                                       input logic ee, input logic el, input logic ep);
        return {18'd0, so, vo, eo, d, m, ee, el, ep};
    endfunction

    function automatic logic [31:0] obs();
        return pk(bus.sof_out, bus.valid_out, bus.eof_out, bus.ds, bus.ds_mask,
                  bus.err_sof_early, bus.err_sof_late, bus.err_param);
    endfunction

    task automatic cyc(input logic s, input logic [7:0] p, input logic [7:0] c, input logic v);
        bus.sof      = s;
        bus.pm       = p;
        bus.cm       = c;
        bus.valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input string tag, input logic so, input logic vo, input logic eo,
                      input logic [3:0] d, input logic [3:0] m,
                      input logic ee, input logic el, input logic ep);
        chk(tag, obs(), pk(so, vo, eo, d, m, ee, el, ep));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.sof = 1'b0; bus.pm = '0; bus.cm = '0; bus.valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ex("reset", 0,0,0, 4'h0,4'h0, 0,0,0);
        rst_n = 1'b1;

        // pm=8 cm=5
        cyc(1, 8, 5, 0); ex("s1_sof",   1,0,0, 4'h0,4'h0, 0,0,0);
        cyc(0, 0, 0, 1); ex("s1_b1",    0,1,0, 4'hA,4'hF, 0,0,0);
        cyc(0, 0, 0, 1); ex("s1_b2",    0,1,1, 4'hD,4'hF, 0,0,0);

        // pm=6 cm=6 all data, partial last beat; pm=5 cm=0 sof right after eof
        cyc(1, 6, 6, 0); ex("s2_sof",   1,0,0, 4'h0,4'h0, 0,0,0);
        cyc(0, 0, 0, 1); ex("s2_b1",    0,1,0, 4'hF,4'hF, 0,0,0);
        cyc(0, 0, 0, 1); ex("s2_b2",    0,1,1, 4'h3,4'h3, 0,0,0);
        cyc(1, 5, 0, 0); ex("s2b_sof",  1,0,0, 4'h0,4'h0, 0,0,0);
        cyc(0, 0, 0, 1); ex("s2b_b1",   0,1,0, 4'h0,4'hF, 0,0,0);
        cyc(0, 0, 0, 1); ex("s2b_b2",   0,1,1, 4'h0,4'h1, 0,0,0);

        // valid_in with sof is the header (no error); gaps hold state
        cyc(1, 8, 5, 1); ex("s3_sof",   1,0,0, 4'h0,4'h0, 0,0,0);
        cyc(0, 0, 0, 1); ex("s3_b1",    0,1,0, 4'hA,4'hF, 0,0,0);
        cyc(0, 0, 0, 0); ex("s3_gap1",  0,0,0, 4'h0,4'h0, 0,0,0);
        cyc(0, 0, 0, 0); ex("s3_gap2",  0,0,0, 4'h0,4'h0, 0,0,0);
        cyc(0, 0, 0, 1); ex("s3_b2",    0,1,1, 4'hD,4'hF, 0,0,0);

        // sof mid-frame reloads pm=4 cm=1
        cyc(1, 8, 5, 0); ex("s4_sof",   1,0,0, 4'h0,4'h0, 0,0,0);
        cyc(0, 0, 0, 1); ex("s4_b1",    0,1,0, 4'hA,4'hF, 0,0,0);
        cyc(1, 4, 1, 1); ex("s4_early", 1,0,0, 4'h0,4'h0, 1,0,0);
        cyc(0, 0, 0, 1); ex("s4_b2",    0,1,1, 4'h8,4'hF, 0,0,0);

        // IDLE errors
        cyc(0, 0, 0, 1); ex("s5_late",  0,0,0, 4'h0,4'h0, 0,1,0);
        cyc(1, 8, 9, 0); ex("s5_cmgt",  0,0,0, 4'h0,4'h0, 0,0,1);
        cyc(0, 0, 0, 1); ex("s5_idle",  0,0,0, 4'h0,4'h0, 0,1,0);
        cyc(1, 0, 0, 0); ex("s5_pm0",   0,0,0, 4'h0,4'h0, 0,0,1);
        cyc(0, 0, 0, 0); ex("s5_quiet", 0,0,0, 4'h0,4'h0, 0,0,0);

        // illegal sof mid-frame: both errors, back to IDLE
        cyc(1, 8, 5, 0); ex("s6_sof",   1,0,0, 4'h0,4'h0, 0,0,0);
        cyc(1, 8, 9, 0); ex("s6_bad",   0,0,0, 4'h0,4'h0, 1,0,1);
        cyc(0, 0, 0, 1); ex("s6_idle",  0,0,0, 4'h0,4'h0, 0,1,0);

        // async reset mid-frame
        cyc(1, 8, 5, 0); ex("s7_sof",   1,0,0, 4'h0,4'h0, 0,0,0);
        cyc(0, 0, 0, 1); ex("s7_b1",    0,1,0, 4'hA,4'hF, 0,0,0);
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        ex("s7_rst", 0,0,0, 4'h0,4'h0, 0,0,0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 1); ex("s7_late",  0,0,0, 4'h0,4'h0, 0,1,0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
